// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage's DIV/DIVU requests.
// Returns {remainder, quotient} with a registered ready flag; one quotient bit per cycle.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      signed_div_in,
    input  logic [DATA_WIDTH-1:0]     dived_in,
    input  logic [DATA_WIDTH-1:0]     div_in,
    input  logic                      start_in,
    input  logic                      annul_in,
    output logic [2*DATA_WIDTH-1:0]   res_out,
    output logic                      rdy_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        FREE,
        BY_ZERO,
        ON,
        END
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [2*W:0]      work;
    logic [W-1:0]      abs_div;
    logic              dived_neg;
    logic              div_neg;
    logic              signed_q;
    logic [2*W-1:0]    result;
    logic              armed;

    logic [W-1:0]      abs_dived_in;
    logic [W-1:0]      abs_div_in;
    logic [2*W:0]      shifted;
    logic [W:0]        trial;
    logic [2*W:0]      step_work;
    logic [W-1:0]      quo_raw;
    logic [W-1:0]      rem_raw;
    logic [W-1:0]      quo_fix;
    logic [W-1:0]      rem_fix;
    logic              deliver;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FREE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (annul_in) begin
            state_next = FREE;
        end else begin
            case (state)
                FREE: begin
                    if (start_in && armed) begin
                        state_next = (div_in == '0) ? BY_ZERO : ON;
                    end
                end
                BY_ZERO: state_next = END;
                ON: begin
                    if (cnt == CW'(W - 1)) begin
                        state_next = END;
                    end
                end
                END: begin
                    if (!start_in) begin
                        state_next = FREE;
                    end
                end
                default: state_next = FREE;
            endcase
        end
    end

    // One restoring step: shift, trial-subtract the divisor, keep the difference if it did not borrow.
    always_comb begin
        abs_dived_in = (signed_div_in && dived_in[W-1]) ? -dived_in : dived_in;
        abs_div_in   = (signed_div_in && div_in[W-1])   ? -div_in   : div_in;
        shifted      = {work[2*W-1:0], 1'b0};
        trial        = shifted[2*W:W] - {1'b0, abs_div};
        step_work    = trial[W] ? shifted : {trial, shifted[W-1:1], 1'b1};
        quo_raw      = step_work[W-1:0];
        rem_raw      = step_work[2*W-1:W];
        quo_fix      = (signed_q && (dived_neg ^ div_neg)) ? -quo_raw : quo_raw;
        rem_fix      = (signed_q && dived_neg) ? -rem_raw : rem_raw;
        deliver      = (state == END) && start_in && !annul_in;
    end

    // armed blocks a start level that is still high from the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            work      <= '0;
            abs_div   <= '0;
            dived_neg <= 1'b0;
            div_neg   <= 1'b0;
            signed_q  <= 1'b0;
            result    <= '0;
            armed     <= 1'b1;
            rdy_out   <= 1'b0;
            res_out   <= '0;
        end else begin
            if (!start_in) begin
                armed <= 1'b1;
            end else if (state == END) begin
                armed <= 1'b0;
            end
            rdy_out <= deliver;
            res_out <= deliver ? result : '0;
            case (state)
                FREE: begin
                    if (state_next == ON) begin
                        cnt       <= '0;
                        work      <= {{(W+1){1'b0}}, abs_dived_in};
                        abs_div   <= abs_div_in;
                        dived_neg <= dived_in[W-1];
                        div_neg   <= div_in[W-1];
                        signed_q  <= signed_div_in;
                    end
                end
                BY_ZERO: begin
                    result <= '0;
                end
                ON: begin
                    work <= step_work;
                    cnt  <= cnt + 1'b1;
                    if (state_next == END) begin
                        result <= {rem_fix, quo_fix};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table-driven vectors through a scoreboard queue,
// plus hand-written annul, held-start and asynchronous reset sequences.
module tb_div_unit;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        signed_div_in;
    logic [31:0] dived_in;
    logic [31:0] div_in;
    logic        start_in;
    logic        annul_in;
    logic [63:0] res_out;
    logic        rdy_out;

    int          vec_count;
    int          err_count;
    logic [63:0] exp_q[$];
    vec_t        vecs[$];

    div_unit #(.DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .signed_div_in (signed_div_in),
        .dived_in      (dived_in),
        .div_in        (div_in),
        .start_in      (start_in),
        .annul_in      (annul_in),
        .res_out       (res_out),
        .rdy_out       (rdy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 32'h0) return 64'h0;
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
        vec_count++;
        if (act !== expv) begin
            err_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Runs one request with start held, checks latency, result, hold in END and the drop to FREE.
    task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  input logic [63:0] expv, input int exp_lat, input bit scramble);
        int          n;
        bit          got;
        logic [63:0] want;
        @(posedge clk); #1;
        signed_div_in = sgn;
        dived_in      = a;
        div_in        = b;
        start_in      = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        if (scramble) begin
            dived_in      = $urandom;
            div_in        = $urandom;
            signed_div_in = ~sgn;
        end
        n   = 0;
        got = 0;
        while (!got && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (rdy_out) got = 1;
        end
        want = exp_q.pop_front();
        check_output("latency", 64'(n), 64'(exp_lat));
        if (got) begin
            check_output("result", res_out, want);
            repeat (2) @(posedge clk);
            #1;
            check_output("held_rdy", {63'h0, rdy_out}, 64'h1);
            check_output("held_res", res_out, want);
        end
        start_in = 1'b0;
        @(posedge clk); #1;
        check_output("drop_rdy", {63'h0, rdy_out}, 64'h0);
        check_output("drop_res", res_out, 64'h0);
    endtask

    task automatic watch_idle(input string name, input int cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (rdy_out || res_out != 64'h0) seen = 1;
        end
        check_output(name, {63'h0, seen}, 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        bit          got;

        vec_count     = 0;
        err_count     = 0;
        rst_n         = 1'b0;
        signed_div_in = 1'b0;
        dived_in      = '0;
        div_in        = '0;
        start_in      = 1'b0;
        annul_in      = 1'b0;

        vecs.push_back('{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                   33});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD},    33});
        vecs.push_back('{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},            33});
        vecs.push_back('{1'b1, 32'd5,          32'd0,          64'h0,                             2});
        vecs.push_back('{1'b0, 32'd5,          32'd0,          64'h0,                             2});
        vecs.push_back('{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000},            33});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF,  32'h10,         {32'hF, 32'h0FFF_FFFF},            33});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'h0000_000E},    33});
        for (int i = 0; i < 8; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            vecs.push_back('{s, a, b, ref_div(s, a, b), (b == 0) ? 2 : 33});
        end

        #22;
        check_output("reset_rdy", {63'h0, rdy_out}, 64'h0);
        check_output("reset_res", res_out, 64'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, i == 0);
        end

        // Annul during the tenth ON cycle, then a fresh request.
        @(posedge clk); #1;
        signed_div_in = 1'b0; dived_in = 32'd100; div_in = 32'd7; start_in = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        annul_in = 1'b1;
        start_in = 1'b0;
        @(posedge clk); #1;
        annul_in = 1'b0;
        check_output("annul_rdy", {63'h0, rdy_out}, 64'h0);
        watch_idle("annul_idle", 40);
        apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33, 0);

        // Annul in END with start still high: no result and no restart.
        @(posedge clk); #1;
        signed_div_in = 1'b0; dived_in = 32'd20; div_in = 32'd0; start_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("end_rdy", {63'h0, rdy_out}, 64'h1);
        annul_in = 1'b1;
        @(posedge clk); #1;
        annul_in = 1'b0;
        check_output("end_annul_rdy", {63'h0, rdy_out}, 64'h0);
        watch_idle("no_restart", 40);
        start_in = 1'b0;

        // Asynchronous reset while a result is being presented.
        apply_stimulus(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, 0);
        @(posedge clk); #1;
        dived_in = 32'd50; div_in = 32'd5; start_in = 1'b1;
        n = 0; got = 0;
        while (!got && n < 60) begin
            @(posedge clk); #1;
            n++;
            if (rdy_out) got = 1;
        end
        check_output("pre_reset_rdy", {63'h0, rdy_out}, 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rdy", {63'h0, rdy_out}, 64'h0);
        check_output("async_res", res_out, 64'h0);
        start_in = 1'b0;
        #3;
        rst_n = 1'b1;

        // Asynchronous reset mid-ON, then a new request.
        @(posedge clk); #1;
        dived_in = 32'd100; div_in = 32'd3; start_in = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midon_rdy", {63'h0, rdy_out}, 64'h0);
        check_output("midon_res", res_out, 64'h0);
        start_in = 1'b0;
        #3;
        rst_n = 1'b1;
        apply_stimulus(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
